// File: rtl/jt12_busdrv.sv
// jt12_busdrv: serialises YM2612 register writes onto the chip's parallel bus.
// Each request becomes an address cycle and a data cycle. Each cycle has a set-up,
// a low write strobe and a recovery with the bus released. A status poll then
// waits for the busy flag to clear before the next request is taken.
// Optional feature: define JT12_BUSDRV_TIMEOUT_EN to bound the busy poll to
// TMO_CYC cycles and to report an expired poll on the sticky timeout_err flag.
module jt12_busdrv #(
    parameter int STB_CYC   = 2,
    parameter int REC_CYC   = 2,
    parameter int GUARD_CYC = 4,
    parameter int TMO_CYC   = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_part,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_val,
    input  logic [7:0] ym_dout,
    output logic [1:0] ym_addr,
    output logic [7:0] ym_din,
    output logic       ym_cs_n,
    output logic       ym_wr_n,
    output logic       timeout_err
);

`ifdef JT12_BUSDRV_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    // Terminal counts for the shared wait counter. The counter starts at 0 on state entry.
    localparam logic [15:0] STB_LAST  = 16'(STB_CYC - 1);
    localparam logic [15:0] REC_LAST  = 16'(REC_CYC - 1);
    localparam logic [15:0] GUARD_CNT = 16'(GUARD_CYC);
    localparam logic [15:0] TMO_LAST  = 16'(TMO_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        A_SET,
        A_STB,
        A_REC,
        D_SET,
        D_STB,
        D_REC,
        POLL
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic        part_q;
    logic [7:0]  reg_q;
    logic [7:0]  val_q;

    // Only the busy bit of the status byte matters here.
    logic unused_status;
    assign unused_status = ^ym_dout[6:0];

    // Bus sequencer. Every output is produced here as a register.
    // The value assigned on a transition is the value the next state presents.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            req_ready   <= 1'b0;
            ym_cs_n     <= 1'b1;
            ym_wr_n     <= 1'b1;
            ym_addr     <= 2'b00;
            ym_din      <= 8'h00;
            timeout_err <= 1'b0;
            part_q      <= 1'b0;
            reg_q       <= 8'h00;
            val_q       <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    ym_cs_n <= 1'b1;
                    ym_wr_n <= 1'b1;
                    ym_addr <= 2'b00;
                    ym_din  <= 8'h00;
                    cnt     <= '0;
                    if (req_valid && req_ready) begin
                        part_q      <= req_part;
                        reg_q       <= req_reg;
                        val_q       <= req_val;
                        req_ready   <= 1'b0;
                        timeout_err <= 1'b0;
                        state       <= A_SET;
                        ym_cs_n     <= 1'b0;
                        ym_addr     <= {req_part, 1'b0};
                        ym_din      <= req_reg;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end

                A_SET: begin
                    state   <= A_STB;
                    cnt     <= '0;
                    ym_wr_n <= 1'b0;
                end

                A_STB: begin
                    if (cnt == STB_LAST) begin
                        state   <= A_REC;
                        cnt     <= '0;
                        ym_cs_n <= 1'b1;
                        ym_wr_n <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                A_REC: begin
                    if (cnt == REC_LAST) begin
                        state   <= D_SET;
                        cnt     <= '0;
                        ym_cs_n <= 1'b0;
                        ym_addr <= {part_q, 1'b1};
                        ym_din  <= val_q;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                D_SET: begin
                    state   <= D_STB;
                    cnt     <= '0;
                    ym_wr_n <= 1'b0;
                end

                D_STB: begin
                    if (cnt == STB_LAST) begin
                        state   <= D_REC;
                        cnt     <= '0;
                        ym_cs_n <= 1'b1;
                        ym_wr_n <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                D_REC: begin
                    if (cnt == REC_LAST) begin
                        state   <= POLL;
                        cnt     <= '0;
                        ym_cs_n <= 1'b0;
                        ym_addr <= 2'b00;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                POLL: begin
                    // Busy is ignored during the guard window. The chip may not
                    // have raised the flag yet right after the data strobe.
                    if ((cnt >= GUARD_CNT) && !ym_dout[7]) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        req_ready <= 1'b1;
                        ym_cs_n   <= 1'b1;
                        ym_addr   <= 2'b00;
                        ym_din    <= 8'h00;
                    end else if (TMO_EN && (cnt == TMO_LAST)) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        req_ready   <= 1'b1;
                        timeout_err <= 1'b1;
                        ym_cs_n     <= 1'b1;
                        ym_addr     <= 2'b00;
                        ym_din      <= 8'h00;
                    end else if (cnt != 16'hFFFF) begin
                        // The counter saturates so that an endless wait never wraps back into the guard window.
                        cnt <= cnt + 16'd1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    req_ready <= 1'b0;
                    ym_cs_n   <= 1'b1;
                    ym_wr_n   <= 1'b1;
                    ym_addr   <= 2'b00;
                    ym_din    <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jt12_busdrv.sv
// tb_jt12_busdrv: scoreboard bench for jt12_busdrv. Each request pushes its two
// expected strobes (address, then data). A bus monitor pops an entry at the end
// of every observed write strobe and compares address, data and width.
module tb_jt12_busdrv;

    localparam int STB = 2;
`ifdef JT12_BUSDRV_TIMEOUT_EN
    localparam int BUSY_HOLD = 12;
`else
    localparam int BUSY_HOLD = 20;
`endif

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_part;
    logic [7:0] req_reg;
    logic [7:0] req_val;
    logic [7:0] ym_dout;
    logic [1:0] ym_addr;
    logic [7:0] ym_din;
    logic       ym_cs_n;
    logic       ym_wr_n;
    logic       timeout_err;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] din;
        int         width;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    jt12_busdrv #(
        .STB_CYC(2),
        .REC_CYC(2),
        .GUARD_CYC(4),
        .TMO_CYC(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_part(req_part),
        .req_reg(req_reg),
        .req_val(req_val),
        .ym_dout(ym_dout),
        .ym_addr(ym_addr),
        .ym_din(ym_din),
        .ym_cs_n(ym_cs_n),
        .ym_wr_n(ym_wr_n),
        .timeout_err(timeout_err)
    );

    // Free-running clock with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // This watchdog stops the run if a wait is never satisfied.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Bus monitor. It samples on the falling clock edge and checks each completed write strobe against the scoreboard.
    initial begin
        logic       prev_wr_n;
        logic [1:0] prev_addr;
        logic [7:0] prev_din;
        logic       in_stb;
        int         width;
        logic [1:0] cap_addr;
        logic [7:0] cap_din;
        exp_t       e;
        prev_wr_n = 1'b1;
        prev_addr = 2'b00;
        prev_din  = 8'h00;
        in_stb    = 1'b0;
        width     = 0;
        cap_addr  = 2'b00;
        cap_din   = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_stb = 1'b0;
            end else if (!ym_wr_n) begin
                if (prev_wr_n) begin
                    total++;
                    if (ym_addr !== prev_addr || ym_din !== prev_din || ym_cs_n !== 1'b0) begin
                        bad++;
                        $display("[TB] FAIL strobe_setup: got addr=%h din=%h cs_n=%b want addr=%h din=%h cs_n=0",
                                 ym_addr, ym_din, ym_cs_n, prev_addr, prev_din);
                    end
                    in_stb   = 1'b1;
                    width    = 1;
                    cap_addr = ym_addr;
                    cap_din  = ym_din;
                end else if (in_stb) begin
                    width++;
                    if (ym_addr !== cap_addr || ym_din !== cap_din) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL strobe_hold: got addr=%h din=%h want addr=%h din=%h",
                                 ym_addr, ym_din, cap_addr, cap_din);
                    end
                end
            end else if (in_stb) begin
                in_stb = 1'b0;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_strobe: got addr=%h din=%h want none", cap_addr, cap_din);
                end else begin
                    e = exp_q.pop_front();
                    if (cap_addr !== e.addr || cap_din !== e.din || width != e.width) begin
                        bad++;
                        $display("[TB] FAIL strobe_data: got addr=%h din=%h w=%0d want addr=%h din=%h w=%0d",
                                 cap_addr, cap_din, width, e.addr, e.din, e.width);
                    end
                end
            end
            prev_wr_n = ym_wr_n;
            prev_addr = ym_addr;
            prev_din  = ym_din;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request, queue its two expected strobes and wait for acceptance. Returns the number of edges waited.
    task automatic send_req(input logic p, input logic [7:0] r, input logic [7:0] v, output int waited);
        logic acc;
        logic got;
        req_valid = 1'b1;
        req_part  = p;
        req_reg   = r;
        req_val   = v;
        exp_q.push_back('{addr: {p, 1'b0}, din: r, width: STB});
        exp_q.push_back('{addr: {p, 1'b1}, din: v, width: STB});
        waited = 0;
        got    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            acc = req_ready;
            step();
            waited++;
            if (acc) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: got no acceptance want acceptance");
        end
    endtask

    // Count rising edges until req_ready is seen high. Returns at the falling edge where it was seen.
    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (req_ready) break;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        req_part  = 1'b0;
        req_reg   = 8'h00;
        req_val   = 8'h00;
        ym_dout   = 8'h00;
        repeat (3) step();
        @(negedge clk);
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready: got %b want 0", req_ready); end
        total++;
        if (ym_cs_n !== 1'b1) begin bad++; $display("[TB] FAIL rst_cs_n: got %b want 1", ym_cs_n); end
        total++;
        if (ym_wr_n !== 1'b1) begin bad++; $display("[TB] FAIL rst_wr_n: got %b want 1", ym_wr_n); end
        total++;
        if (ym_addr !== 2'b00) begin bad++; $display("[TB] FAIL rst_addr: got %h want 0", ym_addr); end
        total++;
        if (ym_din !== 8'h00) begin bad++; $display("[TB] FAIL rst_din: got %h want 00", ym_din); end
        total++;
        if (timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_tmo: got %b want 0", timeout_err); end
        step();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_release_ready: got %b want 1", req_ready); end
        step();
    endtask

    task automatic test_single();
        int w;
        int n;
        send_req(1'b0, 8'h28, 8'hF0, w);
        req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (ym_cs_n !== 1'b0 || ym_wr_n !== 1'b1 || ym_addr !== 2'd0 || ym_din !== 8'h28) begin
            bad++;
            $display("[TB] FAIL single_aset: got cs=%b wr=%b addr=%h din=%h want cs=0 wr=1 addr=0 din=28",
                     ym_cs_n, ym_wr_n, ym_addr, ym_din);
        end
        wait_ready(n);
        total++;
        if (n != 15) begin bad++; $display("[TB] FAIL single_latency: got %0d want 15", n); end
        total++;
        if (ym_cs_n !== 1'b1 || ym_wr_n !== 1'b1 || ym_addr !== 2'd0 || ym_din !== 8'h00) begin
            bad++;
            $display("[TB] FAIL single_idle: got cs=%b wr=%b addr=%h din=%h want cs=1 wr=1 addr=0 din=00",
                     ym_cs_n, ym_wr_n, ym_addr, ym_din);
        end
        step();
    endtask

    task automatic test_part2();
        int w;
        int n;
        send_req(1'b1, 8'hA4, 8'h22, w);
        req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (ym_addr !== 2'd2 || ym_din !== 8'hA4) begin
            bad++;
            $display("[TB] FAIL part2_aset: got addr=%h din=%h want addr=2 din=a4", ym_addr, ym_din);
        end
        wait_ready(n);
        total++;
        if (n != 15) begin bad++; $display("[TB] FAIL part2_latency: got %0d want 15", n); end
        step();
    endtask

    task automatic test_busy();
        int   w;
        logic early;
        ym_dout = 8'h80;
        send_req(1'b0, 8'hB4, 8'hC0, w);
        req_valid = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 10 + BUSY_HOLD; i++) begin
            @(negedge clk);
            if (req_ready) early = 1'b1;
            step();
        end
        total++;
        if (early !== 1'b0) begin bad++; $display("[TB] FAIL busy_early_ready: got 1 want 0"); end
        total++;
        if (ym_cs_n !== 1'b0 || ym_wr_n !== 1'b1 || ym_addr !== 2'd0) begin
            bad++;
            $display("[TB] FAIL busy_poll_bus: got cs=%b wr=%b addr=%h want cs=0 wr=1 addr=0",
                     ym_cs_n, ym_wr_n, ym_addr);
        end
        ym_dout = 8'h00;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL busy_drop_same: got %b want 0", req_ready); end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL busy_drop_next: got %b want 1", req_ready); end
`ifndef JT12_BUSDRV_TIMEOUT_EN
        total++;
        if (timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL busy_tmo_tied: got %b want 0", timeout_err); end
`endif
        step();
    endtask

    task automatic test_back_to_back();
        int w;
        int n;
        send_req(1'b0, 8'h30, 8'h11, w);
        send_req(1'b1, 8'h40, 8'h22, w);
        total++;
        if (w != 16) begin bad++; $display("[TB] FAIL b2b_gap1: got %0d want 16", w); end
        send_req(1'b0, 8'hB0, 8'h33, w);
        total++;
        if (w != 16) begin bad++; $display("[TB] FAIL b2b_gap2: got %0d want 16", w); end
        req_valid = 1'b0;
        wait_ready(n);
        total++;
        if (n != 15) begin bad++; $display("[TB] FAIL b2b_last_latency: got %0d want 15", n); end
        step();
    endtask

    task automatic test_reset_mid();
        int   w;
        logic stray;
        send_req(1'b1, 8'h50, 8'h77, w);
        req_valid = 1'b0;
        repeat (6) step();
        total++;
        if (ym_wr_n !== 1'b0 || ym_addr !== 2'd3) begin
            bad++;
            $display("[TB] FAIL rmid_in_dstb: got wr=%b addr=%h want wr=0 addr=3", ym_wr_n, ym_addr);
        end
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        total++;
        if (ym_cs_n !== 1'b1 || ym_wr_n !== 1'b1 || req_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rmid_abort: got cs=%b wr=%b rdy=%b want cs=1 wr=1 rdy=0",
                     ym_cs_n, ym_wr_n, req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL rmid_ready: got %b want 1", req_ready); end
        stray = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ym_cs_n !== 1'b1) stray = 1'b1;
        end
        total++;
        if (stray !== 1'b0) begin bad++; $display("[TB] FAIL rmid_no_replay: got cs activity want none"); end
        step();
    endtask

`ifdef JT12_BUSDRV_TIMEOUT_EN
    task automatic test_timeout();
        int w;
        int n;
        ym_dout = 8'h80;
        send_req(1'b0, 8'h2B, 8'h80, w);
        req_valid = 1'b0;
        wait_ready(n);
        total++;
        if (n != 26) begin bad++; $display("[TB] FAIL tmo_latency: got %0d want 26", n); end
        total++;
        if (timeout_err !== 1'b1) begin bad++; $display("[TB] FAIL tmo_set: got %b want 1", timeout_err); end
        step();
        ym_dout = 8'h00;
        send_req(1'b0, 8'h2A, 8'h55, w);
        req_valid = 1'b0;
        total++;
        if (timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL tmo_clear: got %b want 0", timeout_err); end
        wait_ready(n);
        total++;
        if (n != 15) begin bad++; $display("[TB] FAIL tmo_next_latency: got %0d want 15", n); end
        step();
    endtask
`endif

    // Scenario sequence.
    initial begin
        test_reset();
        test_single();
        test_part2();
        test_busy();
        test_back_to_back();
        test_reset_mid();
`ifdef JT12_BUSDRV_TIMEOUT_EN
        test_timeout();
`endif
        repeat (5) step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
